usb_sched: RTL
==============

# usb_sched

Transaction scheduler in front of `usb_cs`. It arbitrates between six ADC data channels and one command-reply requester, and drives the `usb_cs` send handshake with the correct bag type and `data_idx`. It services the `usb_cs` read handshake independently, so a send request can never deadlock an inbound packet. It sits between the ADC buffer control and `usb_cs` in the collect USB path.

## Interface
- `SEND_TIMEOUT`, default 16'hFFFF: watchdog limit in `S_SEND`, in cycles.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: when low, data channels receive no new grants; commands are still served.
- `ch_req`  in  6: per-channel send request, level. Held by the requester until its `ch_done`.
- `ch_done`  out  6: one-cycle completion pulse for the granted channel.
- `cmd_req`  in  1: command-reply request, level. Held until `cmd_done`.
- `cmd_btype`  in  4: bag type for the command reply.
- `cmd_done`  out  1: one-cycle completion pulse for the command reply.
- `fs_send`  out  1: to `usb_cs`.
- `fd_send`  in  1: from `usb_cs`.
- `send_btype`  out  4: to `usb_cs`.
- `data_idx`  out  12: to `usb_cs`, values 0–5.
- `fs_read`  in  1: from `usb_cs`.
- `fd_read`  out  1: to `usb_cs`.
- `read_btype`  in  4: from `usb_cs`.
- `cmd_valid`  out  1: one-cycle pulse when an inbound packet is accepted.
- `cmd_rx_btype`  out  4: latched `read_btype`.
- `busy`  out  1: high in any state other than `S_IDLE` or `S_ARB`.
- `err_timeout`  out  1: sticky watchdog flag.

## Operation
- States:
  - `S_IDLE`: reset state. Next state is always `S_ARB`.
  - `S_ARB`: choose a winner.
  - `S_SEND`: assert `fs_send`; wait for `fd_send`.
  - `S_DROP`: release `fs_send`; wait for `fd_send` low.
  - `S_DONE`: pulse completion.
- Arbitration in `S_ARB`:
  - `cmd_req` has strict priority.
  - Otherwise, when `enable` is high, the winner is the first set bit of `ch_req` scanning upward from `rr_ptr` and wrapping 5→0.
  - With no candidate, stay in `S_ARB`.
- On a grant, register `sel_cmd`, `sel_ch`, `send_btype` and `data_idx`, then go to `S_SEND`:
  - Command grant: `send_btype` = `cmd_btype`, `data_idx` = 0.
  - Data grant: `send_btype` = 4'b1101 (DATA0) if `tog[ch]` = 0, else 4'b1110 (DATA1); `data_idx` = `ch`.
- `fs_send` = (state == `S_SEND`), decoded from the state register.
- `S_SEND` → `S_DROP` when `fd_send` = 1.
- `S_DROP` → `S_DONE` when `fd_send` = 0.
- `S_DONE` → `S_ARB` unconditionally. In `S_DONE`:
  - Command grant: `cmd_done` pulses.
  - Data grant: `ch_done[sel_ch]` pulses, `tog[sel_ch]` flips, and `rr_ptr` advances to `sel_ch`+1, wrapping 5→0.
- `send_btype` and `data_idx` are held stable from `S_SEND` through `S_DONE`.
- Watchdog:
  - 16-bit `wd_cnt` counts in `S_SEND` and is cleared in every other state.
  - When `wd_cnt` reaches `SEND_TIMEOUT`-1, `err_timeout` sets and stays set until `rst`.
  - The FSM keeps waiting; `fs_send` is never dropped before `fd_send`.
- Read path, independent of the FSM and active in every state:
  - `fd_read` <= `fs_read` & ~`fd_read`.
  - On the same cycle `fd_read` rises, `cmd_valid` pulses and `cmd_rx_btype` <= `read_btype`.
- Reset values:
  - State `S_IDLE`, `rr_ptr` 0, `tog` 6'b0, `wd_cnt` 0.
  - `send_btype` 4'b0000, `data_idx` 0, `cmd_rx_btype` 4'b0000.
  - All other outputs 0.

## Timing
- Grant latency: a request present in `S_ARB` at cycle N gives `fs_send` = 1 at cycle N+1.
- Release: `fd_send` sampled high at cycle M gives `fs_send` = 0 at cycle M+1.
- Completion: the `done` pulse occurs one cycle after `fd_send` is first sampled low in `S_DROP`. The next arbitration happens in the following cycle.
- Minimum spacing between two sends: 4 cycles plus the `usb_cs` latency.
- Read handshake: `fs_read` high at cycle R gives `fd_read` = 1 and `cmd_valid` = 1 at cycle R+1, both low at R+2. This holds even while `fs_send` is asserted; `usb_cs` gives the read path priority only from `MAIN_WAIT`, so the read is served regardless.
- A requester dropping `ch_req` or `cmd_req` after its grant does not abort the transaction.
- `enable` falling mid-transaction does not abort; it only blocks the next data grant.
- `rst` mid-transaction: every output returns to its reset value on the next edge, and `fs_send` drops immediately.

## Test plan
- Reset, then `ch_req` = 6'b000100 with an `fd_send` model that answers 3 cycles after `fs_send` and releases 1 cycle after `fs_send` drops → `data_idx` = 2, `send_btype` = 4'b1101, `ch_done` = 6'b000100 pulse. A second request on ch2 gives `send_btype` = 4'b1110.
- `ch_req` = 6'b111111 held → grant order 0,1,2,3,4,5,0; each channel's `send_btype` alternates DATA0/DATA1.
- `cmd_req` = 1 with `cmd_btype` = 4'b0110 while `ch_req` = 6'b000011 → command served first (`send_btype` = 4'b0110, `data_idx` = 0, `cmd_done`), then ch0 and ch1.
- `enable` = 0 with `ch_req` = 6'b001000 → no `fs_send`. Raising `enable` → grant within 1 cycle.
- Hold `fs_send` waiting (`fd_send` never rises) while pulsing `fs_read` with `read_btype` = 4'b0101 → `fd_read` and `cmd_valid` one cycle later, `cmd_rx_btype` = 4'b0101. With `SEND_TIMEOUT` = 16, `err_timeout` sets at the 16th cycle of `S_SEND`.
- Assert `rst` for one cycle during `S_SEND` → `fs_send` = 0, `tog` = 0, and the next grant is ch0 with DATA0.

Source files
------------

// File: rtl/usb_sched_if.sv
// -----------------------------------------------------------------------------
// usb_sched_if
// Handshake bundle between the transaction scheduler and usb_cs.
//   Send path : fs_send (sched->cs), fd_send (cs->sched),
//               send_btype / data_idx (sched->cs, stable while fs_send is high)
//   Read path : fs_read / read_btype (cs->sched), fd_read (sched->cs)
// Modports:
//   master - the scheduler side (usb_sched)
//   slave  - the usb_cs side
// -----------------------------------------------------------------------------
interface usb_sched_if;
    logic        fs_send;
    logic        fd_send;
    logic [3:0]  send_btype;
    logic [11:0] data_idx;
    logic        fs_read;
    logic        fd_read;
    logic [3:0]  read_btype;

    modport master (
        output fs_send, send_btype, data_idx, fd_read,
        input  fd_send, fs_read, read_btype
    );

    modport slave (
        input  fs_send, send_btype, data_idx, fd_read,
        output fd_send, fs_read, read_btype
    );
endinterface

// File: rtl/usb_sched.sv
// -----------------------------------------------------------------------------
// usb_sched
// Transaction scheduler in front of usb_cs. Arbitrates six ADC data channels
// (round robin) and one command-reply requester (strict priority), drives the
// usb_cs send handshake with bag type and data_idx, and answers the usb_cs read
// handshake independently of the send FSM.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   enable        - gates new data-channel grants (commands always served)
//   ch_req[5:0]   - per-channel level requests, held until ch_done
//   ch_done[5:0]  - one-cycle completion pulse for the granted channel
//   cmd_req       - command-reply level request, held until cmd_done
//   cmd_btype     - bag type used for the command reply
//   cmd_done      - one-cycle completion pulse for the command reply
//   cmd_valid     - one-cycle pulse when an inbound packet is accepted
//   cmd_rx_btype  - bag type of the last accepted inbound packet
//   busy          - a send transaction is in progress
//   err_timeout   - sticky: fd_send did not arrive within SEND_TIMEOUT cycles
//   usb           - usb_sched_if.master handshake bundle towards usb_cs
// -----------------------------------------------------------------------------
module usb_sched #(
    parameter logic [15:0] SEND_TIMEOUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [5:0]  ch_req,
    output logic [5:0]  ch_done,
    input  logic        cmd_req,
    input  logic [3:0]  cmd_btype,
    output logic        cmd_done,
    output logic        cmd_valid,
    output logic [3:0]  cmd_rx_btype,
    output logic        busy,
    output logic        err_timeout,
    usb_sched_if.master usb
);

    localparam int         NCH      = 6;
    localparam logic [3:0] BT_DATA0 = 4'b1101;
    localparam logic [3:0] BT_DATA1 = 4'b1110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SEND,
        S_DROP,
        S_DONE
    } state_t;

    state_t      state;
    logic [2:0]  rr_ptr;
    logic [5:0]  tog;
    logic [15:0] wd_cnt;
    logic        sel_cmd;
    logic [2:0]  sel_ch;
    logic [3:0]  send_btype;
    logic [11:0] data_idx;
    logic        fd_read;

    // Round-robin search: first requesting channel at or above rr_ptr,
    // wrapping 5 -> 0.
    logic       found;
    logic [2:0] win_ch;
    logic [3:0] cand;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        found  = 1'b0;
        win_ch = '0;
        cand   = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = {1'b0, rr_ptr} + 4'(i);
            if (cand >= 4'(NCH)) cand = cand - 4'(NCH);
            if (!found && ch_req[cand[2:0]]) begin
                found  = 1'b1;
                win_ch = cand[2:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            tog         <= '0;
            wd_cnt      <= '0;
            sel_cmd     <= 1'b0;
            sel_ch      <= '0;
            send_btype  <= '0;
            data_idx    <= '0;
            ch_done     <= '0;
            cmd_done    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            ch_done  <= '0;
            cmd_done <= 1'b0;
            wd_cnt   <= '0;
            case (state)
                S_IDLE: state <= S_ARB;

                S_ARB: begin
                    if (cmd_req) begin
                        sel_cmd    <= 1'b1;
                        sel_ch     <= '0;
                        send_btype <= cmd_btype;
                        data_idx   <= '0;
                        state      <= S_SEND;
                    end else if (enable && found) begin
                        sel_cmd    <= 1'b0;
                        sel_ch     <= win_ch;
                        send_btype <= tog[win_ch] ? BT_DATA1 : BT_DATA0;
                        data_idx   <= 12'(win_ch);
                        state      <= S_SEND;
                    end
                end

                S_SEND: begin
                    // Saturate rather than wrap so a long stall never looks fresh.
                    if (wd_cnt != '1) wd_cnt <= wd_cnt + 16'd1;
                    // Flag is set on the edge where wd_cnt becomes SEND_TIMEOUT-1,
                    // so both are visible in the same cycle.
                    if (wd_cnt + 16'd1 == SEND_TIMEOUT - 16'd1) err_timeout <= 1'b1;
                    if (usb.fd_send) state <= S_DROP;
                end

                S_DROP: begin
                    if (!usb.fd_send) begin
                        state <= S_DONE;
                        // Registered here so the pulse is high during S_DONE.
                        if (sel_cmd) cmd_done <= 1'b1;
                        else         ch_done  <= 6'd1 << sel_ch;
                    end
                end

                S_DONE: begin
                    if (!sel_cmd) begin
                        tog[sel_ch] <= ~tog[sel_ch];
                        rr_ptr      <= (sel_ch == 3'(NCH - 1)) ? 3'd0 : sel_ch + 3'd1;
                    end
                    state <= S_ARB;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Inbound path: one-cycle acknowledge for every fs_read, in any FSM state,
    // so an outstanding send can never block a received packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            fd_read      <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_rx_btype <= '0;
        end else begin
            fd_read   <= usb.fs_read & ~fd_read;
            cmd_valid <= usb.fs_read & ~fd_read;
            if (usb.fs_read && !fd_read) cmd_rx_btype <= usb.read_btype;
        end
    end

    assign busy           = (state != S_IDLE) && (state != S_ARB);
    assign usb.fs_send    = (state == S_SEND);
    assign usb.send_btype = send_btype;
    assign usb.data_idx   = data_idx;
    assign usb.fd_read    = fd_read;

endmodule
